// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Optional trailing-checksum feature is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned ADDR_STEP = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        WR   = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Number of instructions that fit between the base address and the end of memory.
    function automatic int unsigned capacity_words(input int unsigned depth,
                                                   input int unsigned base);
        return (depth > base) ? (depth - base) / ADDR_STEP : 0;
    endfunction

endpackage

// File: rtl/loader_csum.sv
// 8-bit running-sum accumulator for the loader's trailing checksum byte.
// Used only when IMEM_LOADER_CHECKSUM_EN is defined.
module loader_csum
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              add_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              zero_c
);

    logic [BYTE_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            sum_q <= '0;
        end else if (add_en_i) begin
            sum_q <= BYTE_W'(sum_q + byte_i);
        end
    end

    // True when the byte currently presented would bring the running sum to zero.
    assign zero_c = (BYTE_W'(sum_q + byte_i) == '0);

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader: packs high/low byte pairs into 16-bit instructions and writes
// them to consecutive even addresses. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 16,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  num_words,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    localparam int unsigned       CAP  = capacity_words(MEM_DEPTH, BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                hs_c;

    assign hs_c = in_valid && in_ready_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic csum_clr_c;
    logic csum_add_c;
    logic csum_zero_c;

    assign csum_clr_c = (state_q == IDLE) && start && !done_q;
    assign csum_add_c = hs_c && ((state_q == HI) || (state_q == LO));

    loader_csum u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (csum_clr_c),
        .add_en_i (csum_add_c),
        .byte_i   (in_data),
        .zero_c   (csum_zero_c)
    );
`endif

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        in_ready_d  = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE; a start coinciding with it is dropped.
                if (start && !done_q) begin
                    rem_d  = num_words;
                    addr_d = BASE;
                    idx_d  = '0;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (num_words == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = HI;
                        in_ready_d = 1'b1;
                    end
                end
            end
            HI: begin
                in_ready_d = 1'b1;
                if (hs_c) begin
                    hi_d    = in_data;
                    state_d = LO;
                end
            end
            LO: begin
                in_ready_d = 1'b1;
                if (hs_c) begin
                    in_ready_d = 1'b0;
                    state_d    = WR;
                    if (32'(idx_q) < CAP) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = {hi_q, in_data};
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR: begin
                addr_d = addr_q + STEP;
                rem_d  = rem_q - ADDR_W'(1);
                idx_d  = idx_q + ADDR_W'(1);
                if (rem_d != '0) begin
                    state_d    = HI;
                    in_ready_d = 1'b1;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d    = CHK;
                    in_ready_d = 1'b1;
`else
                    state_d    = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                in_ready_d = 1'b1;
                if (hs_c) begin
                    in_ready_d = 1'b0;
                    state_d    = DONE;
                    if (!csum_zero_c) begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= BASE;
            rem_q       <= '0;
            idx_q       <= '0;
            hi_q        <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes/done results,
// a negedge monitor pops and compares them against what the loader presents.
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned MEM_DEPTH = 16;
    localparam int unsigned BASE_ADDR = 0;
    localparam int          CAP       = (MEM_DEPTH - BASE_ADDR) / 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] num_words = '0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t  exp_wr[$];
    logic exp_done[$];
    logic [7:0] stim[0:63];

    imem_loader #(
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every write strobe and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("cpu_hold_eq_busy", 64'(cpu_hold), 64'(busy));
            if (in_ready) check("ready_only_loading", 64'({mem_we, done, !busy}), 64'(0));
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_data", 64'(mem_wdata), 64'(e.data));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    logic e_err;
                    e_err = exp_done.pop_front();
                    check("done_err", 64'(err), 64'(e_err));
                    check("done_busy_low", 64'(busy), 64'(0));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("byte_accept_timeout", 64'(t), 64'(0));
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Runs one load of n words from stim[]; abort_at >= 0 stops after that many bytes.
    task automatic run_load(input int n, input int min_gap, input int max_gap, input int abort_at);
        logic [7:0] sum;
        int t;
        sum = 8'h00;
        @(negedge clk);
        start     = 1'b1;
        num_words = ADDR_W'(n);
        if (abort_at < 0) exp_done.push_back(n > CAP);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        for (int i = 0; i < n; i++) begin
            wr_t w;
            if (abort_at == 2 * i) return;
            send_byte(stim[2*i], $urandom_range(max_gap, min_gap));
            sum = sum + stim[2*i];
            if (abort_at == 2 * i + 1) return;
            if (i < CAP) begin
                w.addr = ADDR_W'(BASE_ADDR + 2 * i);
                w.data = {stim[2*i], stim[2*i+1]};
                exp_wr.push_back(w);
            end
            send_byte(stim[2*i+1], $urandom_range(max_gap, min_gap));
            sum = sum + stim[2*i+1];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (n > 0) send_byte(8'(-sum), $urandom_range(max_gap, min_gap));
`endif
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 64'(done), 64'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err}), 64'(0));
        rst = 1'b0;

        // Fixed stream, back-to-back, then with 3-cycle gaps between bytes.
        for (int i = 0; i < 8; i++) stim[i] = (i == 7) ? 8'h11 : 8'h10;
        run_load(4, 0, 0, -1);
        run_load(4, 3, 3, -1);

        // Empty load, then a start that collides with the done pulse.
        run_load(0, 0, 0, -1);
        start     = 1'b1;
        num_words = ADDR_W'(2);
        @(negedge clk);
        start = 1'b0;
        check("start_during_done_ignored", 64'(busy), 64'(0));
        @(negedge clk);
        check("still_idle", 64'({busy, in_ready}), 64'(0));

        // Capacity overflow: nine words into an eight-entry window.
        for (int i = 0; i < 18; i++) stim[i] = 8'($urandom);
        run_load(9, 0, 1, -1);

        // Reset after the high byte of word 2, then reload from the base address.
        for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
        run_load(4, 0, 1, 5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_load_reset", 64'({in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, err}), 64'(0));
        rst = 1'b0;
        run_load(3, 0, 1, -1);

        // Randomized loads around the capacity boundary.
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(10, 0);
            for (int i = 0; i < 2 * n; i++) stim[i] = 8'($urandom);
            run_load(n, 0, 2, -1);
        end

        repeat (3) @(negedge clk);
        check("sb_writes_drained", 64'(exp_wr.size()), 64'(0));
        check("sb_dones_drained", 64'(exp_done.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
